alu_muldiv_iter: RTL

//  Parametrised iterative multiply/divide unit (RV32M ops) that works alongside the single-cycle ALU in EX.

---
 rtl/alu_muldiv_iter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter
//   Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU.
//   One operation is accepted per start_i pulse while ready_o is high. MUL* ops
//   run a radix-2 shift/add over WIDTH cycles, and DIV*/REM* ops run a
//   restoring divide over WIDTH cycles. The signed result is then returned
//   with a one-cycle valid_o pulse. Divide-by-zero and signed overflow are
//   resolved at acceptance and finish in a single cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   start_i   in   operation request, taken only while ready_o=1
//   op_i      in   funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   num1_i    in   rs1 (multiplicand / dividend)
//   num2_i    in   rs2 (multiplier / divisor)
//   flush_i   in   abort; wins over start_i and over completion
//   ready_o   out  unit idle
//   busy_o    out  stall request to EX (BUSY or DONE)
//   valid_o   out  one-cycle pulse while result_o carries a new result
//   result_o  out  registered result, held until the next completion
`timescale 1ns/1ps
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int               W2       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op;
  logic             neg_q;     // sign of product / quotient
  logic             neg_r;     // sign of remainder (= dividend sign)
  logic [WIDTH-1:0] opb;       // multiplicand or divisor magnitude
  logic [W2-1:0]    acc;       // {high/remainder, low/multiplier/quotient}
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result;

  // Two's-complement sign correction of a magnitude.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [W2-1:0] neg_if_wide(input logic [W2-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand decode at acceptance
  logic             sgn1_en, sgn2_en, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             is_div, div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    sgn1_en = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    sgn2_en = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
  end

  assign neg1     = sgn1_en && num1_i[WIDTH-1];
  assign neg2     = sgn2_en && num2_i[WIDTH-1];
  assign mag1     = neg_if(num1_i, neg1);
  assign mag2     = neg_if(num2_i, neg2);
  assign is_div   = op_i[2];
  assign div_zero = is_div && (num2_i == '0);
  // Only DIV/REM (op_i[0]=0) can overflow: most-negative / -1.
  assign div_ovf  = is_div && !op_i[0] && (num1_i == MOST_NEG) && (num2_i == ALL_ONES);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op_i[1] ? num1_i : ALL_ONES;
    else          special_res = op_i[1] ? '0 : num1_i;
  end

  // One iteration step
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_trial, div_rem;
  logic             div_ge;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    prod_signed;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    // Shift/add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator right by one.
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Restoring divide: shift the next dividend bit into the partial
    // remainder; subtract the divisor when it fits and record a quotient bit.
    div_trial = acc[W2-1:WIDTH-1];
    div_ge    = div_trial >= {1'b0, opb};
    div_rem   = div_ge ? (div_trial - {1'b0, opb}) : div_trial;
    div_next  = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    acc_step  = op[2] ? div_next : mul_next;

    prod_signed = neg_if_wide(acc_step, neg_q);
    final_res   = '0;
    case (op)
      3'd0:                final_res = acc_step[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    final_res = prod_signed[W2-1:WIDTH];
      3'd4, 3'd5:          final_res = neg_if(acc_step[WIDTH-1:0], neg_q);
      default:             final_res = neg_if(acc_step[W2-1:WIDTH], neg_r);
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = special ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers; a flush freezes them so result_o keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush_i) begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op    <= op_i;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            opb   <= is_div ? mag2 : mag1;
            acc   <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
            cnt   <= '0;
            if (special) result <= special_res;
          end
        end
        S_BUSY: begin
          acc <= acc_step;
          if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
          else                 result <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state == S_IDLE);
  assign busy_o   = (state != S_IDLE);
  assign valid_o  = (state == S_DONE);
  assign result_o = result;

endmodule
